// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_core
// Parametrised VGA timing generator with a latency-matched pixel output stage.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int RGB_W    = 16,
   parameter int PIPE_LAT = 2,
   parameter int CHK_LOG2 = 5,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic             vga_clk,
   input  logic             sys_reset,
   input  logic [1:0]       pattern_sel,
   input  logic [RGB_W-1:0] pix_rgb,
   output logic [X_W-1:0]   ovga_x,
   output logic [Y_W-1:0]   ovga_y,
   output logic             req,
   output logic             frame_start,
   output logic             line_start,
   output logic [7:0]       frame_cnt,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic             vga_valid,
   output logic [RGB_W-1:0] vga_rgb
);

   localparam int c_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [X_W-1:0] c_H_LAST   = X_W'(c_H_TOT - 1);
   localparam logic [X_W-1:0] c_H_ACT    = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] c_X_MAX    = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0] c_HS_BEG   = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] c_HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [Y_W-1:0] c_V_LAST   = Y_W'(c_V_TOT - 1);
   localparam logic [Y_W-1:0] c_V_ACT    = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] c_Y_MAX    = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0] c_VS_BEG   = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] c_VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   // delay-line word: {req, raw hsync, raw vsync, x, y}
   localparam int c_DW = 3 + X_W + Y_W;

   logic [X_W-1:0]  r_h;
   logic [Y_W-1:0]  r_v;
   logic            r_hs_raw;
   logic            r_vs_raw;
   logic [1:0]      r_mode;

   logic            w_h_wrap;
   logic            w_v_wrap;
   logic            w_at_origin;
   logic            w_req;
   logic            w_hs;
   logic            w_vs;
   logic [c_DW-1:0] w_s0;
   logic [c_DW-1:0] w_tap;
   logic            w_d_req;
   logic            w_d_hs;
   logic            w_d_vs;
   logic [X_W-1:0]  w_d_x;
   logic [Y_W-1:0]  w_d_y;
   logic [RGB_W-1:0] w_pix;

   assign w_h_wrap    = (r_h == c_H_LAST);
   assign w_v_wrap    = (r_v == c_V_LAST);
   assign w_at_origin = (r_h == '0) && (r_v == '0);
   assign w_req       = (r_h < c_H_ACT) && (r_v < c_V_ACT);
   assign w_hs        = (r_h >= c_HS_BEG) && (r_h <= c_HS_END);
   assign w_vs        = (r_v >= c_VS_BEG) && (r_v <= c_VS_END);

   always_ff @(posedge vga_clk) begin
      if (sys_reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_h_wrap) begin
         r_h <= '0;
         r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   // Stage 0: coordinates and strobes for the pixel source
   always_ff @(posedge vga_clk) begin
      if (sys_reset) begin
         ovga_x      <= '0;
         ovga_y      <= '0;
         req         <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         r_hs_raw    <= 1'b0;
         r_vs_raw    <= 1'b0;
      end else begin
         ovga_x      <= r_h;
         ovga_y      <= r_v;
         req         <= w_req;
         line_start  <= (r_h == '0);
         frame_start <= w_at_origin;
         r_hs_raw    <= w_hs;
         r_vs_raw    <= w_vs;
      end
   end

   // Pattern is latched only at the frame boundary so a frame never tears
   always_ff @(posedge vga_clk) begin
      if (sys_reset) begin
         r_mode <= 2'd0;
      end else if (w_at_origin) begin
         r_mode <= pattern_sel;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (sys_reset) begin
         frame_cnt <= 8'd0;
      end else if (w_h_wrap && w_v_wrap) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign w_s0 = {req, r_hs_raw, r_vs_raw, ovga_x, ovga_y};

   generate
      if (PIPE_LAT == 0) begin : g_lat0
         assign w_tap = w_s0;
      end else begin : g_latn
         logic [c_DW-1:0] r_dly [PIPE_LAT];

         always_ff @(posedge vga_clk) begin
            if (sys_reset) begin
               for (int i = 0; i < PIPE_LAT; i++) begin
                  r_dly[i] <= '0;
               end
            end else begin
               r_dly[0] <= w_s0;
               for (int i = 1; i < PIPE_LAT; i++) begin
                  r_dly[i] <= r_dly[i-1];
               end
            end
         end

         assign w_tap = r_dly[PIPE_LAT-1];
      end
   endgenerate

   assign w_d_req = w_tap[c_DW-1];
   assign w_d_hs  = w_tap[c_DW-2];
   assign w_d_vs  = w_tap[c_DW-3];
   assign w_d_x   = w_tap[X_W+Y_W-1 -: X_W];
   assign w_d_y   = w_tap[Y_W-1:0];

   always_comb begin
      w_pix = '0;
      case (r_mode)
         2'd0: w_pix = pix_rgb;
         2'd1: begin
            if (w_d_x[CHK_LOG2] ^ w_d_y[CHK_LOG2]) begin
               w_pix = '1;
            end
         end
         2'd2: w_pix = '1;
         default: begin
            if ((w_d_x == '0) || (w_d_x == c_X_MAX) ||
                (w_d_y == '0) || (w_d_y == c_Y_MAX)) begin
               w_pix = '1;
            end
         end
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (sys_reset) begin
         vga_valid <= 1'b0;
         vga_hsync <= !HS_POL;
         vga_vsync <= !VS_POL;
         vga_rgb   <= '0;
      end else begin
         vga_valid <= w_d_req;
         vga_hsync <= w_d_hs ? HS_POL : !HS_POL;
         vga_vsync <= w_d_vs ? VS_POL : !VS_POL;
         vga_rgb   <= w_d_req ? w_pix : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_core
// Scoreboard bench: small-geometry core fully modelled, default-size core line-checked.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_core;

   localparam int AHA = 8;
   localparam int AHF = 1;
   localparam int AHS = 2;
   localparam int AHB = 1;
   localparam int AVA = 4;
   localparam int AVF = 1;
   localparam int AVS = 1;
   localparam int AVB = 1;
   localparam int AHT = AHA + AHF + AHS + AHB;
   localparam int AVT = AVA + AVF + AVS + AVB;
   localparam int LAT = 2;
   localparam int CHK = 1;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       req;
      logic       fs;
      logic       ls;
      logic [7:0] fc;
   } s0_t;

   typedef struct packed {
      logic        valid;
      logic        hs;
      logic        vs;
      logic [15:0] rgb;
   } out_t;

   localparam out_t c_BLANK = '{valid: 1'b0, hs: 1'b0, vs: 1'b1, rgb: 16'h0};

   logic        clk;
   logic        rst;
   logic [1:0]  a_sel;
   logic [15:0] a_pix;
   logic [9:0]  a_x, a_y;
   logic        a_req, a_fs, a_ls, a_hs, a_vs, a_valid;
   logic [7:0]  a_fc;
   logic [15:0] a_rgb;

   logic [1:0]  b_sel;
   logic [15:0] b_pix;
   logic [9:0]  b_x, b_y;
   logic        b_req, b_fs, b_ls, b_hs, b_vs, b_valid;
   logic [7:0]  b_fc;
   logic [15:0] b_rgb;

   int vectors     = 0;
   int miscompares = 0;

   s0_t         sq[$];
   out_t        oq[$];
   logic [15:0] pq[$];
   int mh, mv, mmode, mfc;
   int pix_mode;

   vga_timing_core #(
      .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
      .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
      .HS_POL(1'b1), .VS_POL(1'b0), .RGB_W(16), .PIPE_LAT(LAT),
      .CHK_LOG2(CHK), .X_W(10), .Y_W(10)
   ) u_dut_a (
      .vga_clk(clk), .sys_reset(rst), .pattern_sel(a_sel), .pix_rgb(a_pix),
      .ovga_x(a_x), .ovga_y(a_y), .req(a_req), .frame_start(a_fs),
      .line_start(a_ls), .frame_cnt(a_fc), .vga_hsync(a_hs), .vga_vsync(a_vs),
      .vga_valid(a_valid), .vga_rgb(a_rgb)
   );

   vga_timing_core #(
      .PIPE_LAT(0)
   ) u_dut_b (
      .vga_clk(clk), .sys_reset(rst), .pattern_sel(b_sel), .pix_rgb(b_pix),
      .ovga_x(b_x), .ovga_y(b_y), .req(b_req), .frame_start(b_fs),
      .line_start(b_ls), .frame_cnt(b_fc), .vga_hsync(b_hs), .vga_vsync(b_vs),
      .vga_valid(b_valid), .vga_rgb(b_rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic out_t exp_out(input int x, input int y, input int mode,
                                    input logic [15:0] pix);
      out_t o;
      logic act;
      act     = (x < AHA) && (y < AVA);
      o.valid = act;
      o.hs    = (x >= AHA + AHF) && (x < AHA + AHF + AHS);
      o.vs    = !((y >= AVA + AVF) && (y < AVA + AVF + AVS));
      o.rgb   = 16'h0;
      if (act) begin
         case (mode)
            0: o.rgb = pix;
            1: o.rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 16'hFFFF : 16'h0;
            2: o.rgb = 16'hFFFF;
            default: o.rgb = (x == 0 || x == AHA - 1 || y == 0 || y == AVA - 1)
                             ? 16'hFFFF : 16'h0;
         endcase
      end
      return o;
   endfunction

   // One clock of stimulus; expectations are queued for the monitor
   task automatic step(input logic rst_now);
      logic        was_rst;
      logic [9:0]  xl, yl;
      logic [15:0] pix;
      s0_t         s;
      was_rst = rst;
      @(posedge clk);
      #1;
      if (was_rst) begin
         oq.delete();
         sq.delete();
         pq.delete();
         for (int i = 0; i < LAT + 1; i++) oq.push_back(c_BLANK);
         mh = 0; mv = 0; mmode = 0; mfc = 0;
         a_pix = 16'h0;
         chk("a_reset_state",
             64'({a_x, a_y, a_req, a_fs, a_ls, a_fc, a_valid, a_hs, a_vs, a_rgb}),
             64'({31'd0, 3'b001, 16'h0}));
      end else begin
         xl = 10'(mh);
         yl = 10'(mv);
         if (mh == 0 && mv == 0) mmode = int'(a_sel);
         if (mh == AHT - 1 && mv == AVT - 1) mfc = (mfc + 1) % 256;
         s.x   = xl;
         s.y   = yl;
         s.req = (mh < AHA) && (mv < AVA);
         s.fs  = (mh == 0) && (mv == 0);
         s.ls  = (mh == 0);
         s.fc  = 8'(mfc);
         sq.push_back(s);
         pix = (pix_mode != 0) ? 16'hFFFF : {xl[5:0], yl};
         pq.push_back(pix);
         oq.push_back(exp_out(mh, mv, mmode, pix));
         if (mh == AHT - 1) begin
            mh = 0;
            mv = (mv == AVT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
         a_pix = (pq.size() == LAT + 1) ? pq.pop_front() : 16'h0;
      end
      rst = rst_now;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0);
   endtask

   always @(negedge clk) begin
      s0_t  s_exp, s_act;
      out_t o_exp, o_act;
      if (sq.size() > 0) begin
         s_exp = sq.pop_front();
         s_act = {a_x, a_y, a_req, a_fs, a_ls, a_fc};
         chk("a_stage0", 64'(s_act), 64'(s_exp));
      end
      if (oq.size() > LAT + 1) begin
         o_exp = oq.pop_front();
         o_act = {a_valid, a_hs, a_vs, a_rgb};
         chk("a_output", 64'(o_act), 64'(o_exp));
      end
   end

   initial begin
      int found, vcnt, hlow, hfirst, nxt, bad_rgb, bad_x, bad_vs, fs_seen;
      rst = 1'b1; a_sel = 2'd0; a_pix = 16'h0; pix_mode = 0;
      b_sel = 2'd0; b_pix = 16'hFFFF;
      step(1'b1); step(1'b1); step(1'b0);

      run(AHT * AVT);                      // coordinate-tagged pixels
      pix_mode = 1;
      run(AHT * AVT);                      // blanking vs constant white source
      run(2 * AHT);
      a_sel = 2'd3;                        // mid-frame switch must not tear
      run(AHT * AVT - 2 * AHT);
      run(AHT * AVT);                      // border frame
      a_sel = 2'd1;
      run(AHT * AVT);                      // checkerboard frame
      a_sel = 2'd2;
      run(AHT * AVT);                      // solid white frame
      a_sel = 2'd0;
      pix_mode = 0;
      run(AHT * 2);

      while (!(mh == 5 && mv == 2)) step(1'b0);
      step(1'b1);                          // presents (5,2), raises reset
      step(1'b0);                          // reset edge
      run(257 * AHT * AVT + 5);            // frame counter wrap

      // Default-geometry core, zero latency, white external source
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(negedge clk);
         if (b_ls && b_y < 10'd479) found = 1;
      end
      chk("b_find_active_line", 64'(found), 64'd1);
      vcnt = 0; hlow = 0; hfirst = -1; nxt = -1;
      bad_rgb = 0; bad_x = 0; bad_vs = 0; fs_seen = 0;
      for (int t = 1; t <= 800; t++) begin
         @(negedge clk);
         if (t < 800 && b_x != 10'(t)) bad_x++;
         if (b_ls && nxt < 0) nxt = t;
         if (b_valid) vcnt++;
         if (b_valid ? (b_rgb !== 16'hFFFF) : (b_rgb !== 16'h0)) bad_rgb++;
         if (!b_hs) begin
            hlow++;
            if (hfirst < 0) hfirst = t;
         end
         if (!b_vs) bad_vs++;
         if (b_fs) fs_seen++;
      end
      chk("b_line_length", 64'(nxt), 64'd800);
      chk("b_x_sequence_errors", 64'(bad_x), 64'd0);
      chk("b_valid_per_line", 64'(vcnt), 64'd640);
      chk("b_rgb_blank_errors", 64'(bad_rgb), 64'd0);
      chk("b_hsync_low_cycles", 64'(hlow), 64'd96);
      chk("b_hsync_start", 64'(hfirst), 64'd657);
      chk("b_vsync_active_in_line", 64'(bad_vs), 64'd0);
      chk("b_frame_start_in_line", 64'(fs_seen), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
